// File: rtl/wb_bram_ctrl.sv
// Wishbone slave in front of a single-port BRAM with a one-cycle registered read.
// Read and write wait-states are inserted before the BRAM access so that the
// block behaves like a slower external memory. Ack arrives D+1 cycles after
// the accepting cycle, where D is RD_DELAYS or WR_DELAYS.
module wb_bram_ctrl #(
  parameter int          BITS      = 32,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int          RD_DELAYS = 10,
  parameter int          WR_DELAYS = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [BITS-1:0]   wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [BITS-1:0]   wbs_dat_o,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [BITS-1:0]   bram_di,
  input  logic [BITS-1:0]   bram_do,
  output logic [ADDR_W-1:0] bram_a,
  output logic              busy
);

  localparam int MAX_D = (RD_DELAYS > WR_DELAYS) ? RD_DELAYS : WR_DELAYS;
  // One extra bit so cnt can reach D without wrapping inside a transaction.
  localparam int CNT_W = $clog2(MAX_D) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_DELAYS - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_DELAYS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [3:0]        sel;
    logic [BITS-1:0]   dat;
    logic [ADDR_W-1:0] adr;
  } req_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  req_t             req;
  logic             hit, accept, last;

  // Byte-lane bits of the address are don't-care for word accesses.
  logic unused_adr_lsb;
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  assign hit    = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign accept = wbs_cyc_i & wbs_stb_i & hit;
  // Final wait cycle: the BRAM access is issued here and nowhere else.
  assign last   = (state == WAIT) && (cnt == (req.we ? WR_LAST : RD_LAST));

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  // Wait counter and request capture on accept
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
      req <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) req <= '{we: wbs_we_i, sel: wbs_sel_i, dat: wbs_dat_i,
                               adr: wbs_adr_i[ADDR_W+1:2]};
        end
        WAIT:    cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Next-state logic; a dropped cycle during WAIT aborts the transfer
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: begin
        if (!wbs_cyc_i) state_nx = IDLE;
        else if (last)  state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: BRAM strobe on the last wait cycle, ack (gated by cyc) in RESP
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 4'h0;
    wbs_ack_o = 1'b0;
    wbs_dat_o = '0;
    if (last) begin
      bram_en = 1'b1;
      if (req.we) bram_we = req.sel;
    end
    if (state == RESP && wbs_cyc_i) begin
      wbs_ack_o = 1'b1;
      if (!req.we) wbs_dat_o = bram_do;
    end
  end

  assign bram_a  = req.adr;
  assign bram_di = req.dat;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: instance 0 (10/10 wait-states) runs directed cases
// then random traffic against a cycle-offset model; instance 1 (1/3) runs
// directed latency cases.
module tb_wb_bram_ctrl;
  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam int RD0 = 10, WR0 = 10, RD1 = 1, WR1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic [31:0] dati[2];
  logic [31:0] adr [2];
  logic        ack [2];
  logic [31:0] dato[2];
  logic        en  [2];
  logic [3:0]  bwe [2];
  logic [31:0] bdi [2];
  logic [9:0]  ba  [2];
  logic        busy[2];

  int nerr = 0;
  int nchk = 0;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [31:0] mem [1024];
    logic [31:0] dq;
    wb_bram_ctrl #(
      .BITS(32), .ADDR_W(10), .BASE_ADDR(BASE),
      .RD_DELAYS(g == 0 ? RD0 : RD1), .WR_DELAYS(g == 0 ? WR0 : WR1)
    ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst[g]), .wbs_cyc_i(cyc[g]), .wbs_stb_i(stb[g]),
      .wbs_we_i(we[g]), .wbs_sel_i(sel[g]), .wbs_dat_i(dati[g]), .wbs_adr_i(adr[g]),
      .wbs_ack_o(ack[g]), .wbs_dat_o(dato[g]), .bram_en(en[g]), .bram_we(bwe[g]),
      .bram_di(bdi[g]), .bram_do(dq), .bram_a(ba[g]), .busy(busy[g])
    );
    initial for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    // Read-first BRAM with byte write enables
    always @(posedge clk) begin
      if (en[g]) begin
        for (int b = 0; b < 4; b++)
          if (bwe[g][b]) mem[ba[g]][8*b +: 8] <= bdi[g][8*b +: 8];
        dq <= mem[ba[g]];
      end
    end
  end

  // ---------------- reference model for instance 0 ----------------
  // A request accepted in cycle t0 is described only by its offset k from t0:
  // busy for 1..D+1, BRAM access at k==D, ack at k==D+1 (if cyc still high).
  logic [31:0] ref_mem [1024];
  bit          model_on = 0;
  bit          pend = 0;
  int          now = 0, t0 = 0, k = 0, d = 0;
  bit          p_we;
  logic [3:0]  p_sel;
  logic [31:0] p_dat;
  logic [9:0]  p_w;
  bit          e_busy, e_en, e_ack;
  logic [3:0]  e_we;
  logic [31:0] e_dat;

  initial for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

  function automatic bit in_window(input logic [31:0] a);
    return (a >> 12) == (BASE >> 12);
  endfunction

  // Compare instance 0 against the model every cycle, then advance the model
  always @(negedge clk) begin
    if (model_on) begin
      e_busy = 0; e_en = 0; e_ack = 0; e_we = 4'h0; e_dat = 32'h0;
      if (pend) begin
        k = now - t0;
        d = p_we ? WR0 : RD0;
        e_busy = 1;
        if (k == d) begin
          e_en = 1;
          e_we = p_we ? p_sel : 4'h0;
        end
        if (k == d + 1) begin
          e_ack = cyc[0];
          if (e_ack && !p_we) e_dat = ref_mem[p_w];
        end
      end
      chk("m_busy", busy[0], e_busy);
      chk("m_en",   en[0],   e_en);
      chk("m_we",   bwe[0],  e_we);
      chk("m_ack",  ack[0],  e_ack);
      chk("m_dat",  dato[0], e_dat);
      if (e_en) begin
        chk("m_addr", ba[0], p_w);
        if (p_we) chk("m_di", bdi[0], p_dat);
      end
      if (pend) begin
        if (k == d && p_we)
          for (int b = 0; b < 4; b++)
            if (p_sel[b]) ref_mem[p_w][8*b +: 8] = p_dat[8*b +: 8];
        if (k == d + 1 || !cyc[0] || rst[0]) pend = 0;
      end else if (!rst[0] && cyc[0] && stb[0] && in_window(adr[0])) begin
        pend = 1; t0 = now;
        p_we = we[0]; p_sel = sel[0]; p_dat = dati[0]; p_w = adr[0][11:2];
      end
      now++;
    end
  end

  // ---------------- directed transaction helper ----------------
  logic [31:0] h_ack, h_en, h_busy;
  logic [3:0]  h_we  [32];
  logic [9:0]  h_a   [32];
  logic [31:0] h_di  [32];
  logic [31:0] h_dat [32];

  // Cycle 0 is the cycle the request is presented; 32 cycles are recorded.
  task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] dd, input int drop_at, input int rst_at);
    @(posedge clk); #1;
    cyc[i] = 1; stb[i] = 1; we[i] = w; adr[i] = a; sel[i] = s; dati[i] = dd;
    h_ack = '0; h_en = '0; h_busy = '0;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        rst[i] = (c == rst_at);
        if (c == drop_at || c == rst_at || h_ack[c-1]) begin
          cyc[i] = 0; stb[i] = 0;
        end
      end
      @(negedge clk);
      h_ack[c] = ack[i]; h_en[c] = en[i]; h_busy[c] = busy[i];
      h_we[c] = bwe[i]; h_a[c] = ba[i]; h_di[c] = bdi[i]; h_dat[c] = dato[i];
    end
    cyc[i] = 0; stb[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; cyc[i] = 0; stb[i] = 0; we[i] = 0;
      sel[i] = 4'h0; dati[i] = 32'h0; adr[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 model_on = 1;
    @(negedge clk);
    chk("rst_ack", ack[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_en", {en[1], en[0], bwe[0]}, 0);
    @(posedge clk); #1;
    rst[0] = 0; rst[1] = 0;

    // write DEADBEEF to word 4
    txn(0, 1, 32'h3800_0010, 4'hF, 32'hDEADBEEF, -1, -1);
    chk("wr_ack_cycle", h_ack, 32'h0000_0800);
    chk("wr_en_cycle", h_en, 32'h0000_0400);
    chk("wr_we", h_we[10], 4'hF);
    chk("wr_addr", h_a[10], 10'd4);
    chk("wr_di", h_di[10], 32'hDEADBEEF);
    chk("wr_busy", h_busy, 32'h0000_0FFE);

    // read it back
    txn(0, 0, 32'h3800_0010, 4'hF, 32'h0, -1, -1);
    chk("rd_ack_cycle", h_ack, 32'h0000_0800);
    chk("rd_data", h_dat[11], 32'hDEADBEEF);
    chk("rd_dat_c10", h_dat[10], 32'h0);
    chk("rd_dat_c12", h_dat[12], 32'h0);
    chk("rd_we", h_we[10], 4'h0);

    // partial byte write then read
    txn(0, 1, 32'h3800_0010, 4'b0001, 32'h0000_0055, -1, -1);
    txn(0, 0, 32'h3800_0010, 4'hF, 32'h0, -1, -1);
    chk("byte_merge", h_dat[11], 32'hDEADBE55);

    // miss held for the whole window
    txn(0, 0, 32'h3000_0000, 4'hF, 32'h0, -1, -1);
    chk("miss_ack", h_ack, 32'h0);
    chk("miss_en", h_en, 32'h0);
    chk("miss_busy", h_busy, 32'h0);

    // abort a write to word 8, then read word 8
    txn(0, 1, 32'h3800_0020, 4'hF, 32'hCAFE_F00D, 5, -1);
    chk("abort_ack", h_ack, 32'h0);
    chk("abort_en", h_en, 32'h0);
    txn(0, 0, 32'h3800_0020, 4'hF, 32'h0, -1, -1);
    chk("abort_rd_ack", h_ack, 32'h0000_0800);
    chk("abort_rd_data", h_dat[11], init_val(8));

    // reset in cycle 6 of a read, then a normal read
    txn(0, 0, 32'h3800_0010, 4'hF, 32'h0, -1, 6);
    chk("rst_mid_ack", h_ack, 32'h0);
    chk("rst_mid_busy", h_busy & 32'hFFFF_FF80, 32'h0);
    chk("rst_mid_en", h_en, 32'h0);
    txn(0, 0, 32'h3800_0010, 4'hF, 32'h0, -1, -1);
    chk("post_rst_ack", h_ack, 32'h0000_0800);
    chk("post_rst_data", h_dat[11], 32'hDEADBE55);

    // short-delay instance
    txn(1, 1, 32'h3800_0040, 4'hF, 32'h1234_5678, -1, -1);
    chk("b_wr_ack", h_ack, 32'h0000_0010);
    chk("b_wr_en", h_en, 32'h0000_0008);
    txn(1, 0, 32'h3800_0040, 4'hF, 32'h0, -1, -1);
    chk("b_rd_ack", h_ack, 32'h0000_0004);
    chk("b_rd_en", h_en, 32'h0000_0002);
    chk("b_rd_data", h_dat[2], 32'h1234_5678);

    // random traffic on instance 0, including stale strobes, aborts and edge misses
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      cyc[0]  = ($urandom % 20) != 0;
      stb[0]  = ($urandom % 10) < 7;
      we[0]   = 1'($urandom % 2);
      sel[0]  = 4'($urandom);
      dati[0] = $urandom;
      case ($urandom % 8)
        0:       adr[0] = 32'h3000_0000 | 32'($urandom % 4096);
        1:       adr[0] = BASE + 32'h1000 + 32'($urandom % 16);
        2:       adr[0] = BASE + 32'hFFC + 32'($urandom % 4);
        default: adr[0] = BASE | (32'($urandom % 16) << 2) | 32'($urandom % 4);
      endcase
    end
    @(posedge clk); #1;
    cyc[0] = 0; stb[0] = 0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
